// File: rtl/arb_mux_n.sv
// N-way WIDTH-bit selector (round-robin, fixed priority or explicit select)
// feeding one registered valid/ready output stage.
module arb_mux_n #(
  parameter  int unsigned WIDTH    = 32,
  parameter  int unsigned CHANNELS = 8,
  parameter  int unsigned MODE     = 0,
  localparam int unsigned SEL_W    = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                      clock,
  input  logic                      reset_n,
  input  logic [CHANNELS-1:0]       in_valid,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  output logic [CHANNELS-1:0]       in_ready,
  input  logic [SEL_W-1:0]          select,
  output logic                      out_valid,
  output logic [WIDTH-1:0]          out_data,
  output logic [SEL_W-1:0]          out_sel,
  input  logic                      out_ready
);

  localparam int unsigned MODE_RR = 0;
  localparam int unsigned MODE_FP = 1;

  logic [SEL_W-1:0]    rr_ptr;
  logic [SEL_W-1:0]    rr_next;
  logic [SEL_W-1:0]    lo_idx;
  logic [SEL_W-1:0]    hi_idx;
  logic                lo_vld;
  logic                hi_vld;
  logic                sel_vld;
  logic [SEL_W-1:0]    grant_idx;
  logic                grant_vld;
  logic [CHANNELS-1:0] grant_oh;
  logic [WIDTH-1:0]    grant_data;
  logic                load;
  logic                xfer;

  assign load = ~out_valid | out_ready;
  assign xfer = grant_vld & load & reset_n;

  // Lowest valid channel overall, lowest valid at/after rr_ptr, and select match.
  always_comb begin
    lo_idx  = '0;
    lo_vld  = 1'b0;
    hi_idx  = '0;
    hi_vld  = 1'b0;
    sel_vld = 1'b0;
    for (int k = int'(CHANNELS) - 1; k >= 0; k--) begin
      if (in_valid[k]) begin
        lo_idx = SEL_W'(k);
        lo_vld = 1'b1;
        if (k >= int'(rr_ptr)) begin
          hi_idx = SEL_W'(k);
          hi_vld = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      if (select == SEL_W'(k) && in_valid[k]) sel_vld = 1'b1;
    end
  end

  // Round-robin falls back to the lowest valid index when nothing sits at/after rr_ptr.
  always_comb begin
    grant_idx = '0;
    grant_vld = 1'b0;
    case (MODE)
      MODE_RR: begin
        grant_vld = lo_vld;
        grant_idx = hi_vld ? hi_idx : lo_idx;
      end
      MODE_FP: begin
        grant_vld = lo_vld;
        grant_idx = lo_idx;
      end
      default: begin
        grant_vld = sel_vld;
        grant_idx = select;
      end
    endcase
  end

  // AND-OR mux keeps unknown data on non-granted channels away from out_data.
  always_comb begin
    grant_oh   = '0;
    grant_data = '0;
    for (int unsigned k = 0; k < CHANNELS; k++) begin
      grant_oh[k] = grant_vld && (grant_idx == SEL_W'(k));
      grant_data  = grant_data | (in_data[k*WIDTH +: WIDTH] & {WIDTH{grant_oh[k]}});
    end
  end

  assign in_ready = grant_oh & {CHANNELS{load & reset_n}};
  assign rr_next  = (32'(grant_idx) == CHANNELS - 1) ? '0 : grant_idx + SEL_W'(1);

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_sel   <= grant_idx;
      if (MODE == MODE_RR) rr_ptr <= rr_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule
